// File: rtl/id_ex_pipe_pkg.sv
// ID/EX stage shared types and constants.
// Default field widths, NOP encodings and the stage payload record.
package id_ex_pipe_pkg;

  localparam int ALUOP_W_DEF  = 8;
  localparam int ALUSEL_W_DEF = 3;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int CNT_W_DEF    = 16;

  localparam logic [ALUOP_W_DEF-1:0]  OP_NOP    = '0;
  localparam logic [ALUSEL_W_DEF-1:0] SEL_NOP   = '0;
  localparam logic [ADDR_W_DEF-1:0]   ADDR_ZERO = '0;

  localparam logic RST_ON   = 1'b0;
  localparam logic STALL_ON = 1'b1;
  localparam logic FLUSH_ON = 1'b1;

  typedef struct packed {
    logic [ALUOP_W_DEF-1:0]  aluop;
    logic [ALUSEL_W_DEF-1:0] alusel;
    logic [DATA_W_DEF-1:0]   reg0;
    logic [DATA_W_DEF-1:0]   reg1;
    logic [ADDR_W_DEF-1:0]   waddr;
    logic                    we;
  } stage_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_BUSY,
    ST_FULL
  } buf_state_e;

endpackage

// File: rtl/id_ex_pipe_if.sv
// Valid/ready stage bundle carrying one decoded beat.
// The producer side uses master, the consumer side uses slave.
interface id_ex_pipe_if #(
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) ();

  logic                valid;
  logic                ready;
  logic [ALUOP_W-1:0]  aluop;
  logic [ALUSEL_W-1:0] alusel;
  logic [DATA_W-1:0]   reg0;
  logic [DATA_W-1:0]   reg1;
  logic [ADDR_W-1:0]   waddr;
  logic                we;

  modport master (
    output valid, aluop, alusel,
    output reg0, reg1, waddr, we,
    input  ready
  );

  modport slave (
    input  valid, aluop, alusel,
    input  reg0, reg1, waddr, we,
    output ready
  );

endinterface

// File: rtl/id_ex_pipe_skid_buf.sv
// Generic two-entry skid buffer with flush.
// Upstream ready depends only on the registered skid flag.
module pipe_skid_buf
  import id_ex_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         main_v;
  logic         skid_v;
  logic [W-1:0] main_d;
  logic [W-1:0] skid_d;
  logic         accept;
  logic         drain;
  buf_state_e   state;

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign accept    = in_valid & !skid_v;
  assign drain     = main_v & out_ready;

  // Occupancy view derived from the two valid flags.
  always_comb begin
    state = ST_EMPTY;
    if (main_v) state = skid_v ? ST_FULL : ST_BUSY;
  end

  // Entry movement; the skid entry always leaves before newer beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush == FLUSH_ON) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_d <= in_data;
            main_v <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && drain) begin
            main_d <= in_data;
          end else if (accept) begin
            skid_d <= in_data;
            skid_v <= 1'b1;
          end else if (drain) begin
            main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX stage register: skid-buffered handshake,
// stall/flush control, NOP gating and bubble counting.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int ALUOP_W  = ALUOP_W_DEF,
  parameter int ALUSEL_W = ALUSEL_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  id_ex_pipe_if.slave      id,
  id_ex_pipe_if.master     ex,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int PW = ALUOP_W + ALUSEL_W
                    + 2 * DATA_W + ADDR_W + 1;

  logic                stall_on;
  logic                flush_on;
  logic                buf_ready;
  logic                main_v;
  logic                out_valid;
  logic [PW-1:0]       in_pl;
  logic [PW-1:0]       main_pl;
  logic [ALUOP_W-1:0]  m_aluop;
  logic [ALUSEL_W-1:0] m_alusel;
  logic [DATA_W-1:0]   m_reg0;
  logic [DATA_W-1:0]   m_reg1;
  logic [ADDR_W-1:0]   m_waddr;
  logic                m_we;

  assign stall_on = (stall == STALL_ON);
  assign flush_on = (flush == FLUSH_ON);

  assign in_pl = {id.aluop, id.alusel, id.reg0,
                  id.reg1, id.waddr, id.we};

  pipe_skid_buf #(
    .W (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_on),
    .in_valid  (id.valid & !stall_on),
    .in_data   (in_pl),
    .in_ready  (buf_ready),
    .out_valid (main_v),
    .out_data  (main_pl),
    .out_ready (ex.ready & !stall_on)
  );

  assign id.ready  = buf_ready & !stall_on;
  assign out_valid = main_v & !stall_on;

  assign {m_aluop, m_alusel, m_reg0,
          m_reg1, m_waddr, m_we} = main_pl;

  assign ex.valid  = out_valid;
  assign ex.aluop  = out_valid ? m_aluop
                               : ALUOP_W'(OP_NOP);
  assign ex.alusel = out_valid ? m_alusel
                               : ALUSEL_W'(SEL_NOP);
  assign ex.reg0   = m_reg0;
  assign ex.reg1   = m_reg1;
  assign ex.waddr  = m_waddr;
  assign ex.we     = out_valid & m_we;

  // Count cycles the ALU was ready but got nothing; saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (ex.ready && !out_valid
                 && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe against a
// two-slot FIFO reference model.
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] bubble_cnt;
  logic [3:0]  sat_cnt;

  int vectors = 0;
  int errors  = 0;

  stage_t      mq[$];
  stage_t      exp_q[$];
  int unsigned bcnt  = 0;
  int unsigned sat_m = 0;

  id_ex_pipe_if di ();
  id_ex_pipe_if de ();
  id_ex_pipe_if si ();
  id_ex_pipe_if se ();

  always #5 clk = ~clk;

  id_ex_pipe u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .id         (di),
    .ex         (de),
    .bubble_cnt (bubble_cnt)
  );

  id_ex_pipe #(.CNT_W(4)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .stall      (1'b0),
    .flush      (1'b0),
    .id         (si),
    .ex         (se),
    .bubble_cnt (sat_cnt)
  );

  task automatic chk(input string n,
                     input logic [127:0] a,
                     input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic stage_t rnd();
    stage_t p;
    p.aluop  = 8'($urandom);
    p.alusel = 3'($urandom);
    p.reg0   = $urandom;
    p.reg1   = $urandom;
    p.waddr  = 5'($urandom);
    p.we     = 1'($urandom);
    return p;
  endfunction

  function automatic stage_t mk(input logic [7:0] op,
                                input logic [4:0] wa,
                                input logic w);
    stage_t p;
    p       = rnd();
    p.aluop = op;
    p.waddr = wa;
    p.we    = w;
    return p;
  endfunction

  // One clock of stimulus, per-cycle checks and model update.
  task automatic step(input bit v, input bit st,
                      input bit fl, input bit ordy,
                      input stage_t p);
    bit exp_ir;
    bit exp_ov;
    bit acc;
    @(negedge clk);
    di.valid  = v;
    di.aluop  = p.aluop;
    di.alusel = p.alusel;
    di.reg0   = p.reg0;
    di.reg1   = p.reg1;
    di.waddr  = p.waddr;
    di.we     = p.we;
    stall     = st;
    flush     = fl;
    de.ready  = ordy;
    #1;
    exp_ir = !st && (mq.size() < 2);
    exp_ov = rst && !st && (mq.size() > 0);
    chk("in_ready", di.ready, exp_ir);
    chk("out_valid", de.valid, exp_ov);
    chk("bubble_cnt", bubble_cnt, bcnt);
    chk("sat_cnt", sat_cnt, sat_m);
    if (!exp_ov)
      chk("nop_gate", {de.aluop, de.alusel, de.we}, 0);
    if (rst) begin
      if (ordy && !exp_ov && bcnt < 65535) bcnt++;
      if (sat_m < 15) sat_m++;
      if (fl) begin
        mq.delete();
      end else if (!st) begin
        acc = v && (mq.size() < 2);
        if (ordy && mq.size() > 0)
          exp_q.push_back(mq.pop_front());
        if (acc) mq.push_back(p);
      end
    end
  endtask

  // Monitor: every real transfer must match the next expected beat.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (de.valid && de.ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          chk("beat",
              {de.aluop, de.alusel, de.reg0,
               de.reg1, de.waddr, de.we},
              exp_q.pop_front());
        end
      end
    end
  end

  stage_t      ta;
  stage_t      te;
  logic [15:0] b0;

  initial begin
    di.valid  = 1'b0;
    di.aluop  = '0;
    di.alusel = '0;
    di.reg0   = '0;
    di.reg1   = '0;
    di.waddr  = '0;
    di.we     = 1'b0;
    de.ready  = 1'b0;
    si.valid  = 1'b0;
    si.aluop  = '0;
    si.alusel = '0;
    si.reg0   = '0;
    si.reg1   = '0;
    si.waddr  = '0;
    si.we     = 1'b0;
    se.ready  = 1'b1;

    repeat (3) step(1, 0, 0, 1, mk(8'h55, 5'd3, 1'b1));
    chk("rst_aluop", de.aluop, OP_NOP);
    chk("rst_we", de.we, 0);
    chk("rst_waddr", de.waddr, 0);
    chk("rst_reg0", de.reg0, 0);
    chk("rst_bubble", bubble_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    step(1, 0, 0, 1, mk(8'h21, 5'd1, 1'b1));
    step(0, 0, 0, 1, rnd());
    chk("first_valid", de.valid, 1);
    chk("first_aluop", de.aluop, 8'h21);

    step(1, 0, 0, 1, mk(8'hA1, 5'd10, 1'b1));
    step(1, 0, 0, 0, mk(8'hB1, 5'd11, 1'b1));
    ta = mk(8'hC1, 5'd12, 1'b1);
    step(1, 0, 0, 0, ta);
    chk("bp_in_ready", di.ready, 0);
    step(1, 0, 0, 0, ta);
    step(1, 0, 0, 1, ta);
    step(1, 0, 0, 1, ta);
    repeat (3) step(0, 0, 0, 1, rnd());

    step(1, 0, 0, 0, mk(8'hA2, 5'd20, 1'b1));
    step(1, 0, 0, 0, mk(8'hB2, 5'd21, 1'b1));
    step(1, 0, 1, 0, mk(8'hD2, 5'd22, 1'b1));
    step(0, 0, 0, 0, rnd());
    chk("flush_valid", de.valid, 0);
    chk("flush_we", de.we, 0);
    te = mk(8'hE2, 5'd23, 1'b1);
    step(1, 0, 0, 1, te);
    step(0, 0, 0, 1, rnd());
    chk("flush_first", de.aluop, te.aluop);
    repeat (2) step(0, 0, 0, 1, rnd());

    step(1, 0, 0, 0, mk(8'h33, 5'd5, 1'b1));
    b0 = bubble_cnt;
    repeat (3) step(1, 1, 0, 1, mk(8'h44, 5'd6, 1'b1));
    step(0, 0, 0, 1, rnd());
    chk("stall_bubbles", bubble_cnt - b0, 3);
    chk("stall_waddr", de.waddr, 5);
    chk("stall_we", de.we, 1);
    repeat (2) step(0, 0, 0, 1, rnd());
    chk("sat_hold", sat_cnt, 4'hf);

    repeat (400)
      step($urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0,
           rnd());

    step(0, 0, 1, 0, rnd());
    step(1, 0, 0, 0, rnd());
    step(1, 0, 0, 0, rnd());
    @(negedge clk);
    di.valid = 1'b0;
    de.ready = 1'b0;
    #1;
    chk("pre_rst_full", di.ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_out_valid", de.valid, 0);
    chk("async_in_ready", di.ready, 1);
    mq.delete();
    bcnt  = 0;
    sat_m = 0;
    step(0, 0, 0, 1, rnd());
    @(posedge clk);
    #1 rst = 1'b1;
    step(0, 0, 0, 1, rnd());
    chk("post_rst_ready", di.ready, 1);
    step(1, 0, 0, 1, mk(8'hF1, 5'd30, 1'b1));
    repeat (4) step(0, 0, 0, 1, rnd());
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
